// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key matrix scanner.
// Contents: scan FSM state enum, synchronizer depth, cell index helper.
package key_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE
    } scan_state_t;

    localparam int SYNC_STAGES = 2;

    // Flattened bitmap position of the key at column i, row j.
    function automatic int cell_index(int n, int i, int j);
        return n * j + i;
    endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Bundle between the key matrix scanner and its surroundings.
// Ports: ena, row_sense (in to scanner); col_drive, x, cells, frame_done (out).
interface key_matrix_scanner_if #(
    parameter int N = 8
);
    localparam int XW = $clog2(N) + 1;

    logic             ena;
    logic [N-1:0]     row_sense;
    logic [N-1:0]     col_drive;
    logic [XW-1:0]    x;
    logic [N*N-1:0]   cells;
    logic             frame_done;

    modport master (
        input  ena,
        input  row_sense,
        output col_drive,
        output x,
        output cells,
        output frame_done
    );

    modport slave (
        output ena,
        output row_sense,
        input  col_drive,
        input  x,
        input  cells,
        input  frame_done
    );

endinterface

// File: rtl/key_debouncer.sv
// Per-key debouncer, updated only on its column's sample strobe.
// Ports: clk, rst, sample_i, raw_i (in); state_o level, rise_o 0->1 pulse (out).
module key_debouncer #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_i,
    input  logic raw_i,
    output logic state_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    assign flip = sample_i && (raw_i != state_q) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_i) begin
            if (raw_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = raw_i;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    // Combinational so a toggle bitmap updates on the same edge as the level.
    assign rise_o  = flip && raw_i;

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-strobed key matrix scanner with per-key debounce; bit N*j+i = key (i,j).
// Ports: clk, rst, bus (master: ena, row_sense in; col_drive, x, cells, frame_done out).
// Build option KEY_TOGGLE_EN: cells becomes a toggle-on-press latch bitmap.
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int N              = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    key_matrix_scanner_if.master bus
);

    localparam int XW = $clog2(N) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [XW-1:0] X_LAST      = XW'(N - 1);

    // Row synchronizer; idles high like the pulled-up rows.
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
        end else begin
            sync_q[0] <= bus.row_sense;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign raw = ~sync_q[SYNC_STAGES-1];

    scan_state_t   state_q;
    logic [SW-1:0] settle_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] x_next;
    logic [N-1:0]  col_q;
    logic          done_q;

    assign x_next = (x_q == X_LAST) ? '0 : x_q + 1'b1;

    function automatic logic [N-1:0] strobe(logic [XW-1:0] col);
        return ~(N'(1) << col);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            x_q      <= '0;
            col_q    <= '1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    settle_q <= '0;
                    col_q    <= '1;
                    if (bus.ena) begin
                        state_q <= S_DRIVE;
                        x_q     <= '0;
                        col_q   <= strobe('0);
                    end
                end
                S_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q  <= S_SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    x_q    <= x_next;
                    done_q <= (x_q == X_LAST);
                    if (bus.ena) begin
                        state_q <= S_DRIVE;
                        col_q   <= strobe(x_next);
                    end else begin
                        state_q <= S_IDLE;
                        col_q   <= '1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    col_q   <= '1;
                end
            endcase
        end
    end

    logic           sample_w;
    logic [N*N-1:0] level_w;
    logic [N*N-1:0] rise_w;

    assign sample_w = (state_q == S_SAMPLE);

    for (genvar j = 0; j < N; j++) begin : g_row
        for (genvar i = 0; i < N; i++) begin : g_col
            localparam int IDX = cell_index(N, i, j);
            key_debouncer #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_key (
                .clk     (clk),
                .rst     (rst),
                .sample_i(sample_w && (x_q == XW'(i))),
                .raw_i   (raw[j]),
                .state_o (level_w[IDX]),
                .rise_o  (rise_w[IDX])
            );
        end
    end

`ifdef KEY_TOGGLE_EN
    logic [N*N-1:0] cells_q;

    always_ff @(posedge clk) begin
        if (rst) cells_q <= '0;
        else     cells_q <= cells_q ^ rise_w;
    end

    assign bus.cells = cells_q;
`else
    logic unused_rise;
    assign unused_rise = ^rise_w;
    assign bus.cells   = level_w;
`endif

    assign bus.col_drive  = col_q;
    assign bus.x          = x_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner (N=8, settle 4, debounce 3).
// Covers reset, scan order, debounce press/release/bounce, ena drop, toggle build.
module tb_key_matrix_scanner;

    localparam int N  = 8;
    localparam int SC = 4;
    localparam int DS = 3;
    localparam int XW = $clog2(N) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_matrix_scanner_if #(.N(N)) bus_if ();

    key_matrix_scanner #(
        .N             (N),
        .SETTLE_CYCLES (SC),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Diode-isolated matrix: row j pulled low by any pressed key on a driven column.
    logic [N*N-1:0] keys;

    always_comb begin
        bus_if.row_sense = '1;
        for (int j = 0; j < N; j++)
            bus_if.row_sense[j] = ~|(keys[N*j +: N] & ~bus_if.col_drive);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected cells after each driven frame.
    logic [N*N-1:0] sb_q [$];

    always @(posedge clk) begin
        #1;
        if (!rst && bus_if.frame_done && sb_q.size() > 0)
            check("cells_frame", bus_if.cells, sb_q.pop_front());
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.frame_done && n < 100);
        if (!bus_if.frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected pulse");
        end
    endtask

    // k: {key42, key0} pressed; lvl/tog: expected {cells[42], cells[0]}.
    typedef struct {
        logic [1:0] k;
        logic [1:0] lvl;
        logic [1:0] tog;
    } vec_t;

    vec_t tbl [30];
    logic [7:0] cd_tbl [8];

    function automatic logic [N*N-1:0] expand(logic [1:0] v);
        logic [N*N-1:0] r;
        r     = '0;
        r[42] = v[1];
        r[0]  = v[0];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] e;
        int n;

        cd_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                   8'hEF, 8'hDF, 8'hBF, 8'h7F};
        tbl = '{
            '{2'b10, 2'b00, 2'b00}, '{2'b10, 2'b00, 2'b00},
            '{2'b10, 2'b10, 2'b10}, '{2'b10, 2'b10, 2'b10},
            '{2'b00, 2'b10, 2'b10}, '{2'b00, 2'b10, 2'b10},
            '{2'b00, 2'b00, 2'b10}, '{2'b00, 2'b00, 2'b10},
            '{2'b10, 2'b00, 2'b10}, '{2'b00, 2'b00, 2'b10},
            '{2'b10, 2'b00, 2'b10}, '{2'b00, 2'b00, 2'b10},
            '{2'b10, 2'b00, 2'b10}, '{2'b00, 2'b00, 2'b10},
            '{2'b01, 2'b00, 2'b10}, '{2'b01, 2'b00, 2'b10},
            '{2'b01, 2'b01, 2'b11}, '{2'b01, 2'b01, 2'b11},
            '{2'b00, 2'b01, 2'b11}, '{2'b00, 2'b01, 2'b11},
            '{2'b00, 2'b00, 2'b11}, '{2'b00, 2'b00, 2'b11},
            '{2'b01, 2'b00, 2'b11}, '{2'b01, 2'b00, 2'b11},
            '{2'b01, 2'b01, 2'b10}, '{2'b01, 2'b01, 2'b10},
            '{2'b00, 2'b01, 2'b10}, '{2'b00, 2'b01, 2'b10},
            '{2'b00, 2'b00, 2'b10}, '{2'b00, 2'b00, 2'b10}
        };

        rst        = 1'b1;
        bus_if.ena = 1'b1;
        keys       = '0;

        repeat (3) @(negedge clk);
        check("rst_col_drive", bus_if.col_drive, 8'hFF);
        check("rst_cells", bus_if.cells, '0);
        check("rst_frame_done", bus_if.frame_done, 0);
        check("rst_x", bus_if.x, 0);
        rst = 1'b0;

        // Scan order over two frames; frame_done only on first cycle of frame 2.
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < N; c++) begin
                for (int k = 0; k < SC + 1; k++) begin
                    @(negedge clk);
                    check("scan_col_drive", bus_if.col_drive, cd_tbl[c]);
                    check("scan_x", bus_if.x, c);
                    check("scan_frame_done", bus_if.frame_done,
                          (f == 1 && c == 0 && k == 0) ? 1 : 0);
                end
            end
        end

        // Debounce vectors, one per frame, keys applied at frame start.
        wait_frame();
        for (int v = 0; v < 30; v++) begin
            keys = expand(tbl[v].k);
`ifdef KEY_TOGGLE_EN
            e = tbl[v].tog;
`else
            e = tbl[v].lvl;
`endif
            sb_q.push_back(expand(e));
            wait_frame();
        end
        keys = '0;
        check("sb_drain", sb_q.size(), 0);

        // ena dropped two cycles into column 3's DRIVE.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.col_drive != 8'hF7 && n < 100);
        check("ena_find_col3", bus_if.col_drive, 8'hF7);
        repeat (2) @(negedge clk);
        bus_if.ena = 1'b0;
        @(negedge clk);
        check("ena_drive_hold", bus_if.col_drive, 8'hF7);
        @(negedge clk);
        check("ena_sample_hold", bus_if.col_drive, 8'hF7);
        check("ena_sample_x", bus_if.x, 3);
        @(negedge clk);
        check("ena_idle_col", bus_if.col_drive, 8'hFF);
        check("ena_idle_x", bus_if.x, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ena_idle_stay", bus_if.col_drive, 8'hFF);
            check("ena_idle_done", bus_if.frame_done, 0);
        end
        bus_if.ena = 1'b1;
        @(negedge clk);
        check("ena_restart_col", bus_if.col_drive, 8'hFE);
        check("ena_restart_x", bus_if.x, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
